cpu_trace_buffer: RTL and testbench

// - Downstream consumer of the CPU debug outputs (pc, instruction, alu_result, mem_data).
// - Captures one 128-bit retire record per enabled cycle into a FIFO.
// - Drains the FIFO as a byte stream over a valid/ready link (UART/JTAG bridge side).
// - Overflow is counted, never stalls the CPU: the single-cycle core has no backpressure.

---
 rtl/cpu_trace_buffer_if.sv | 22 ++
 rtl/cpu_trace_buffer.sv | 153 +++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_buffer_if.sv
// Byte-stream link from the trace buffer to the debug bridge (UART/JTAG side).
// The buffer drives valid/data/last; the bridge answers with ready.
interface cpu_trace_buffer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// CPU retire trace buffer.
// Captures one 128-bit record {pc, instr, alu, mem} per enabled cycle into a
// FIFO and drains it big-endian as a byte stream. The core cannot be stalled,
// so records arriving to a full FIFO are dropped and counted instead.
module cpu_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trace_en,
  input  logic [31:0]         pc_in,
  input  logic [31:0]         instr_in,
  input  logic [31:0]         alu_in,
  input  logic [31:0]         mem_in,
  cpu_trace_buffer_if.master  stream,
  output logic [ADDR_W:0]     fifo_count,
  output logic                overflow,
  output logic [15:0]         dropped_count,
  input  logic                clear_overflow
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [127:0]        mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [127:0]        shift;
  logic [3:0]          byte_idx;
  logic                pop;
  logic                push;
  logic                drop;
  logic                handshake;
  logic                fifo_nonempty;

  assign fifo_nonempty = (fifo_count != '0);
  assign handshake     = (state == SEND) && stream.out_ready;

  // A push is taken when there is room, or when a pop frees a slot on the same edge.
  assign push = trace_en && ((fifo_count < FULL_COUNT) || pop);
  assign drop = trace_en && !push;

  // Outputs come straight from state/shift registers: no input reaches them combinationally.
  assign stream.out_valid = (state == SEND);
  assign stream.out_data  = shift[127:120];
  assign stream.out_last  = (state == SEND) && (byte_idx == 4'd15);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and pop decision; a new record is loaded right after the last byte so
  // back-to-back records stream without a bubble.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (handshake && (byte_idx == 4'd15)) begin
          if (fifo_nonempty) begin
            pop = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Record storage; contents need no reset because occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pc_in, instr_in, alu_in, mem_in};
    end
  end

  // Read/write pointers wrap naturally at DEPTH (a power of two); occupancy count alongside.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + ONE_COUNT;
        2'b01:   fifo_count <= fifo_count - ONE_COUNT;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Serializer: load a popped record, then shift one byte out per accepted handshake.
  // The shift register is cleared on reset so out_data reads zero while idle after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift    <= '0;
      byte_idx <= '0;
    end else if (pop) begin
      shift    <= mem[rd_ptr];
      byte_idx <= '0;
    end else if (handshake) begin
      shift    <= {shift[119:0], 8'h00};
      byte_idx <= byte_idx + 4'd1;
    end
  end

  // Drop accounting: a drop on the same edge as a clear wins, leaving a count of one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        dropped_count <= 16'd1;
      end else if (dropped_count != 16'hFFFF) begin
        dropped_count <= dropped_count + 16'd1;
      end
    end else if (clear_overflow) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_cpu_trace_buffer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              trace_en = 1'b0;
  logic              clear_overflow = 1'b0;
  logic [31:0]       pc_in = '0;
  logic [31:0]       instr_in = '0;
  logic [31:0]       alu_in = '0;
  logic [31:0]       mem_in = '0;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;
  logic [15:0]       dropped_count;

  cpu_trace_buffer_if sif ();

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .trace_en       (trace_en),
    .pc_in          (pc_in),
    .instr_in       (instr_in),
    .alu_in         (alu_in),
    .mem_in         (mem_in),
    .stream         (sif),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .dropped_count  (dropped_count),
    .clear_overflow (clear_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: FIFO of whole records, the record being sent, and the
  // byte stream the sink should see, in order.
  logic [127:0] q[$];
  logic [7:0]   exp_bytes[$];
  logic [127:0] cur;
  int           cur_idx;
  bit           busy;
  bit           m_ovf;
  int           m_drop;

  function automatic logic [7:0] byte_of(input logic [127:0] r, input int i);
    return r[127-8*i -: 8];
  endfunction

  task automatic model_reset();
    q.delete();
    exp_bytes.delete();
    cur     = '0;
    cur_idx = 0;
    busy    = 1'b0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  task automatic compare_outputs();
    chk("out_valid", sif.out_valid, busy);
    if (busy) begin
      chk("out_data", sif.out_data, byte_of(cur, cur_idx));
      chk("out_last", sif.out_last, cur_idx == 15);
    end else begin
      chk("out_last_idle", sif.out_last, 1'b0);
    end
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("dropped_count", dropped_count, m_drop);
    if (sif.out_valid && sif.out_ready) begin
      chk("stream_avail", exp_bytes.size() > 0, 1'b1);
      if (exp_bytes.size() > 0) chk("stream_byte", sif.out_data, exp_bytes.pop_front());
    end
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    bit hs;
    bit do_pop;
    bit acc;
    logic [127:0] rec;
    rec    = {pc_in, instr_in, alu_in, mem_in};
    hs     = busy && sif.out_ready;
    do_pop = 1'b0;
    if (!busy) begin
      if (q.size() > 0) do_pop = 1'b1;
    end else if (hs) begin
      if (cur_idx == 15) begin
        if (q.size() > 0) do_pop = 1'b1;
        else busy = 1'b0;
      end else begin
        cur_idx++;
      end
    end
    acc = trace_en && ((q.size() < DEPTH) || do_pop);
    if (do_pop) begin
      cur     = q.pop_front();
      cur_idx = 0;
      busy    = 1'b1;
    end
    if (acc) begin
      q.push_back(rec);
      for (int i = 0; i < 16; i++) exp_bytes.push_back(byte_of(rec, i));
    end
    if (clear_overflow) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (trace_en && !acc) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
  endtask

  // One clock: check at the falling edge, update model, pass the rising edge.
  task automatic cycle();
    compare_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rec(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] m);
    pc_in    = p;
    instr_in = i;
    alu_in   = a;
    mem_in   = m;
  endtask

  task automatic rand_rec();
    set_rec($urandom, $urandom, $urandom, $urandom);
  endtask

  logic [7:0] t1_bytes [16];

  initial begin
    t1_bytes = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    sif.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_data", sif.out_data, 8'h00);
    compare_outputs();
    reset = 1'b1;
    @(negedge clk);

    // Single record, exact byte sequence and latency.
    set_rec(32'h0040_0000, 32'h2008_0005, 32'h0000_0005, 32'h0000_0000);
    trace_en = 1'b1;
    sif.out_ready = 1'b1;
    cycle();
    trace_en = 1'b0;
    chk("latency_e", sif.out_valid, 1'b0);
    cycle();
    chk("latency_e1", sif.out_valid, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("t1_byte", sif.out_data, t1_bytes[i]);
      chk("t1_last", sif.out_last, i == 15);
      cycle();
    end
    chk("t1_done", sif.out_valid, 1'b0);
    repeat (2) cycle();

    // Two records back-to-back: 32 contiguous bytes.
    trace_en = 1'b1;
    rand_rec();
    cycle();
    rand_rec();
    cycle();
    trace_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("b2b_valid", sif.out_valid, 1'b1);
      cycle();
    end
    chk("b2b_done", sif.out_valid, 1'b0);
    repeat (2) cycle();

    // Stall for 10 cycles after byte 3 of a record.
    set_rec(32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00);
    trace_en = 1'b1;
    cycle();
    trace_en = 1'b0;
    cycle();
    repeat (4) cycle();
    sif.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_data", sif.out_data, 8'h55);
      chk("stall_valid", sif.out_valid, 1'b1);
      cycle();
    end
    sif.out_ready = 1'b1;
    repeat (14) cycle();
    chk("stall_drained", exp_bytes.size(), 0);

    // Fill with sink blocked: DEPTH+5 captures.
    sif.out_ready = 1'b0;
    trace_en = 1'b1;
    for (int i = 0; i < DEPTH + 5; i++) begin
      rand_rec();
      cycle();
    end
    trace_en = 1'b0;
    chk("full_count", fifo_count, 16);
    chk("full_ovf", overflow, 1'b1);
    chk("full_drop", dropped_count, 4);
    chk("full_valid", sif.out_valid, 1'b1);
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_drop", dropped_count, 0);

    // Full FIFO: pushes drop until the last byte's pop makes room.
    sif.out_ready = 1'b1;
    trace_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_rec();
      cycle();
    end
    trace_en = 1'b0;
    chk("fullpop_count", fifo_count, 16);
    chk("fullpop_drop", dropped_count, 15);

    // Clear coinciding with a drop.
    sif.out_ready = 1'b0;
    trace_en = 1'b1;
    clear_overflow = 1'b1;
    rand_rec();
    cycle();
    trace_en = 1'b0;
    clear_overflow = 1'b0;
    chk("clrdrop_ovf", overflow, 1'b1);
    chk("clrdrop_drop", dropped_count, 1);

    // Asynchronous reset in the middle of a record.
    sif.out_ready = 1'b1;
    repeat (5) cycle();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", sif.out_valid, 1'b0);
    chk("arst_count", fifo_count, 0);
    chk("arst_ovf", overflow, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    set_rec(32'hCAFE_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004);
    trace_en = 1'b1;
    cycle();
    trace_en = 1'b0;
    cycle();
    chk("arst_byte0", sif.out_data, 8'hCA);
    repeat (18) cycle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      trace_en       = ($urandom_range(0, 99) < 20);
      sif.out_ready  = ($urandom_range(0, 99) < 75);
      clear_overflow = ($urandom_range(0, 99) < 3);
      rand_rec();
      cycle();
    end
    trace_en = 1'b0;
    clear_overflow = 1'b0;
    sif.out_ready = 1'b1;
    for (int n = 0; n < 16 * (DEPTH + 2); n++) cycle();
    chk("final_empty", exp_bytes.size(), 0);
    chk("final_idle", sif.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
